exec_sequencer: RTL and testbench

- Instruction sequencer for the single-cycle-per-phase processor core. Replaces the free-running cycle generator.
- Drives the program-memory fetch strobe and the PC/register-file execute strobe.
- Adds run/halt control, single-step, datapath stall, halt-on-self-loop detection and a retired-instruction counter.
- Sits between the top-level switches and the pc, program memory and register-file blocks.

---
 rtl/exec_sequencer_if.sv | 23 ++
 rtl/exec_sequencer.sv | 138 +++++++++++++
 tb/tb_exec_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/exec_sequencer_if.sv
// Datapath-side bus of the instruction sequencer: the execute-unit inputs it
// watches (pc, branch, stall) and the fetch/execute strobes it drives.
interface exec_sequencer_if #(
   parameter int PROG_ADDR_WIDTH = 6
);
   logic                       stall;
   logic [PROG_ADDR_WIDTH-1:0] pc;
   logic                       branch;
   logic [PROG_ADDR_WIDTH-1:0] branch_addr;
   logic                       fetch_en;
   logic                       exec_en;

   // master = sequencer, slave = pc / program memory / register-file side
   modport master (
      input  stall, pc, branch, branch_addr,
      output fetch_en, exec_en
   );

   modport slave (
      output stall, pc, branch, branch_addr,
      input  fetch_en, exec_en
   );
endinterface

// File: rtl/exec_sequencer.sv
// HALT/FETCH/DECODE/EXEC instruction sequencer with run/step/stall control,
// self-loop halt and retired-instruction counter. Optional breakpoint: EXEC_SEQ_BREAKPOINT_EN.
module exec_sequencer #(
   parameter int PROG_ADDR_WIDTH = 6,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   input  logic                 step,
   exec_sequencer_if.master     dp,
   output logic                 halted,
   output logic                 self_loop,
   output logic [CNT_WIDTH-1:0] instr_count
`ifdef EXEC_SEQ_BREAKPOINT_EN
   ,
   input  logic                       bp_en,
   input  logic [PROG_ADDR_WIDTH-1:0] bp_addr,
   output logic                       bp_hit
`endif
);

   typedef enum logic [1:0] {
      S_HALT   = 2'd0,
      S_FETCH  = 2'd1,
      S_DECODE = 2'd2,
      S_EXEC   = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic                 step_q;
   logic                 self_loop_q, self_loop_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 step_rise;
   logic                 exec_fire;
   logic                 self_hit;

   assign step_rise = step & ~step_q;
   // reset gates the strobes so an abandoned instruction never writes back
   assign exec_fire = (state_q == S_EXEC) && !dp.stall && !reset;
   assign self_hit  = dp.branch && (dp.branch_addr == dp.pc);

`ifdef EXEC_SEQ_BREAKPOINT_EN
   logic                       bp_hit_q, bp_hit_d;
   logic [PROG_ADDR_WIDTH-1:0] next_pc;

   assign next_pc = dp.branch ? dp.branch_addr : dp.pc + PROG_ADDR_WIDTH'(1);
`endif

   always_comb begin
      state_d     = state_q;
      self_loop_d = self_loop_q;
      cnt_d       = cnt_q;
`ifdef EXEC_SEQ_BREAKPOINT_EN
      bp_hit_d    = bp_hit_q;
`endif
      case (state_q)
         S_HALT: begin
            if (run) begin
`ifdef EXEC_SEQ_BREAKPOINT_EN
               if (bp_en && (dp.pc == bp_addr)) begin
                  bp_hit_d = 1'b1;
               end else begin
                  state_d     = S_FETCH;
                  self_loop_d = 1'b0;
                  bp_hit_d    = 1'b0;
               end
`else
               state_d     = S_FETCH;
               self_loop_d = 1'b0;
`endif
            end else if (step_rise) begin
               // a step start deliberately skips the breakpoint so the user can step past it
               state_d     = S_FETCH;
               self_loop_d = 1'b0;
`ifdef EXEC_SEQ_BREAKPOINT_EN
               bp_hit_d    = 1'b0;
`endif
            end
         end
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            if (!dp.stall) begin
               cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
               if (self_hit) begin
                  state_d     = S_HALT;
                  self_loop_d = 1'b1;
               end else if (run) begin
`ifdef EXEC_SEQ_BREAKPOINT_EN
                  if (bp_en && (next_pc == bp_addr)) begin
                     state_d  = S_HALT;
                     bp_hit_d = 1'b1;
                  end else begin
                     state_d = S_FETCH;
                  end
`else
                  state_d = S_FETCH;
`endif
               end else begin
                  state_d = S_HALT;
               end
            end
         end
         default: state_d = S_HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_HALT;
         step_q      <= 1'b0;
         self_loop_q <= 1'b0;
         cnt_q       <= '0;
`ifdef EXEC_SEQ_BREAKPOINT_EN
         bp_hit_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         step_q      <= step;
         self_loop_q <= self_loop_d;
         cnt_q       <= cnt_d;
`ifdef EXEC_SEQ_BREAKPOINT_EN
         bp_hit_q    <= bp_hit_d;
`endif
      end
   end

   assign dp.fetch_en = (state_q == S_FETCH) && !reset;
   assign dp.exec_en  = exec_fire;
   assign halted      = (state_q == S_HALT);
   assign self_loop   = self_loop_q;
   assign instr_count = cnt_q;
`ifdef EXEC_SEQ_BREAKPOINT_EN
   assign bp_hit      = bp_hit_q;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer; retire counts flow through a scoreboard
// queue checked on every exec_en pulse.
module tb_exec_sequencer;
   localparam int AW = 6;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset, run, step;
   logic          halted, self_loop;
   logic [CW-1:0] instr_count;
`ifdef EXEC_SEQ_BREAKPOINT_EN
   logic          bp_en;
   logic [AW-1:0] bp_addr;
   logic          bp_hit;
`endif

   exec_sequencer_if #(.PROG_ADDR_WIDTH(AW)) dp_if();

   exec_sequencer #(.PROG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .step        (step),
      .dp          (dp_if),
      .halted      (halted),
      .self_loop   (self_loop),
      .instr_count (instr_count)
`ifdef EXEC_SEQ_BREAKPOINT_EN
      ,
      .bp_en       (bp_en),
      .bp_addr     (bp_addr),
      .bp_hit      (bp_hit)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int nf, ne;
   bit exec_prev = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      nf += int'(dp_if.fetch_en);
      ne += int'(dp_if.exec_en);
   endtask

   task automatic tickn(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // retire monitor: the count after each exec_en pulse must match the queue head
   initial begin
      forever begin
         @(posedge clk);
         #3;
         if (exec_prev) begin
            if (exp_q.size() == 0) check("unexpected_exec", 32'd1, 32'd0);
            else check("retire_count", 32'(instr_count), 32'(exp_q.pop_front()));
         end
         check("strobe_overlap", 32'(dp_if.fetch_en & dp_if.exec_en), 32'd0);
         exec_prev = (dp_if.exec_en === 1'b1);
      end
   end

   initial begin
      reset = 1'b1; run = 1'b0; step = 1'b0;
      dp_if.stall = 1'b0; dp_if.pc = '0; dp_if.branch = 1'b0; dp_if.branch_addr = '0;
`ifdef EXEC_SEQ_BREAKPOINT_EN
      bp_en = 1'b0; bp_addr = '0;
`endif
      nf = 0; ne = 0;

      // reset hold
      tickn(2);
      check("rst_halted", 32'(halted), 32'd1);
      check("rst_fetch", 32'(dp_if.fetch_en), 32'd0);
      check("rst_exec", 32'(dp_if.exec_en), 32'd0);
      check("rst_count", 32'(instr_count), 32'd0);
      check("rst_self_loop", 32'(self_loop), 32'd0);

      // free run: 10 instructions in 30 cycles
      reset = 1'b0; run = 1'b1;
      for (int i = 1; i <= 10; i++) exp_q.push_back(i);
      tick();
      check("run_to_fetch", 32'(dp_if.fetch_en), 32'd1);
      nf = 1; ne = 0;
      tickn(29);
      check("free_fetch_pulses", 32'(nf), 32'd10);
      check("free_exec_pulses", 32'(ne), 32'd10);
      run = 1'b0;
      tick();
      check("free_halted", 32'(halted), 32'd1);
      check("free_count", 32'(instr_count), 32'd10);

      // single step, then a step edge during execution that must not queue
      reset = 1'b1; tick(); reset = 1'b0;
      check("step_rst_count", 32'(instr_count), 32'd0);
      exp_q.push_back(1);
      nf = 0; ne = 0; step = 1'b1;
      tickn(5);
      check("step1_fetches", 32'(nf), 32'd1);
      check("step1_execs", 32'(ne), 32'd1);
      check("step1_halted", 32'(halted), 32'd1);
      check("step1_count", 32'(instr_count), 32'd1);
      step = 1'b0;
      tickn(2);
      exp_q.push_back(2);
      nf = 0; ne = 0; step = 1'b1;
      tick();
      check("step2_fetch", 32'(dp_if.fetch_en), 32'd1);
      step = 1'b0; tick();
      step = 1'b1; tickn(4);
      check("step_edge_ignored", 32'(nf), 32'd1);
      check("step2_execs", 32'(ne), 32'd1);
      check("step2_halted", 32'(halted), 32'd1);
      check("step2_count", 32'(instr_count), 32'd2);

      // stall holds EXEC for 4 cycles
      step = 1'b0;
      reset = 1'b1; tick(); reset = 1'b0;
      run = 1'b1; exp_q.push_back(1);
      tickn(2);
      dp_if.stall = 1'b1; ne = 0;
      tickn(4);
      check("stall_no_exec", 32'(ne), 32'd0);
      check("stall_not_halted", 32'(halted), 32'd0);
      check("stall_count_held", 32'(instr_count), 32'd0);
      dp_if.stall = 1'b0; run = 1'b0;
      #1;
      check("stall_release_exec", 32'(dp_if.exec_en), 32'd1);
      tick();
      check("stall_count", 32'(instr_count), 32'd1);
      check("stall_halted", 32'(halted), 32'd1);

      // self-loop halt under run, then step re-executes it once
      reset = 1'b1; tick(); reset = 1'b0;
      run = 1'b1; dp_if.pc = 6'd5; dp_if.branch = 1'b1; dp_if.branch_addr = 6'd5;
      exp_q.push_back(1);
      tickn(4);
      run = 1'b0;
      check("loop_halted", 32'(halted), 32'd1);
      check("loop_flag", 32'(self_loop), 32'd1);
      check("loop_count", 32'(instr_count), 32'd1);
      exp_q.push_back(2);
      step = 1'b1;
      tick();
      check("loop_step_fetch", 32'(dp_if.fetch_en), 32'd1);
      check("loop_flag_cleared", 32'(self_loop), 32'd0);
      tickn(3);
      check("loop_flag_again", 32'(self_loop), 32'd1);
      check("loop_halted_again", 32'(halted), 32'd1);
      check("loop_count2", 32'(instr_count), 32'd2);
      step = 1'b0; dp_if.branch = 1'b0;

      // reset while stalled in EXEC
      run = 1'b1; dp_if.stall = 1'b1;
      tickn(3);
      check("mid_in_exec", 32'(halted), 32'd0);
      reset = 1'b1; run = 1'b0;
      #1;
      check("mid_rst_no_exec", 32'(dp_if.exec_en), 32'd0);
      tick();
      check("mid_rst_halted", 32'(halted), 32'd1);
      check("mid_rst_count", 32'(instr_count), 32'd0);
      check("mid_rst_fetch", 32'(dp_if.fetch_en), 32'd0);
      reset = 1'b0; dp_if.stall = 1'b0;
      tick();

      // counter saturation at all-ones
      run = 1'b1;
      for (int i = 1; i <= 18; i++) exp_q.push_back((i > 15) ? 15 : i);
      tickn(54);
      run = 1'b0;
      tick();
      check("sat_count", 32'(instr_count), 32'd15);
      check("sat_halted", 32'(halted), 32'd1);

`ifdef EXEC_SEQ_BREAKPOINT_EN
      // breakpoint before fetching address 3; step moves past it
      reset = 1'b1; tick(); reset = 1'b0;
      bp_en = 1'b1; bp_addr = 6'd3; dp_if.pc = 6'd2; dp_if.branch = 1'b0; run = 1'b1;
      exp_q.push_back(1);
      tickn(4);
      check("bp_halted", 32'(halted), 32'd1);
      check("bp_hit_set", 32'(bp_hit), 32'd1);
      check("bp_count", 32'(instr_count), 32'd1);
      dp_if.pc = 6'd3; nf = 0;
      tickn(2);
      check("bp_hold_no_fetch", 32'(nf), 32'd0);
      check("bp_hold_halted", 32'(halted), 32'd1);
      run = 1'b0; step = 1'b1; exp_q.push_back(2);
      tick();
      check("bp_step_fetch", 32'(dp_if.fetch_en), 32'd1);
      check("bp_hit_cleared", 32'(bp_hit), 32'd0);
      step = 1'b0;
      tickn(3);
      check("bp_step_count", 32'(instr_count), 32'd2);
      check("bp_step_halted", 32'(halted), 32'd1);
`endif

      tick();
      check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
